video_out_pal: RTL and testbench

VIDEO_OUT_PAL -- requirements
Module: video_out_pal

---
 rtl/video_pkg.sv | 26 ++
 rtl/dpram.sv | 41 ++++
 rtl/video_fade.sv | 61 ++++++
 rtl/video_out_pal.sv | 113 +++++++++++
 tb/tb_video_out_pal.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared encodings for the palette video output path: pixel depth modes and fade FSM states.
package video_pkg;

    localparam logic [1:0] MODE_8BPP = 2'd0;
    localparam logic [1:0] MODE_4BPP = 2'd1;
    localparam logic [1:0] MODE_2BPP = 2'd2;

    localparam logic [1:0] FADE_IDLE = 2'd0;
    localparam logic [1:0] FADE_UP   = 2'd1;
    localparam logic [1:0] FADE_DOWN = 2'd2;

    typedef logic [1:0] fade_state_t;

    // 2bpp: sub-pixel 0 is the leftmost (most significant) crumb of the byte.
    function automatic logic [1:0] crumb_sel(input logic [7:0] pix, input logic [1:0] sel);
        logic [1:0] crumb;
        case (sel)
            2'd0:    crumb = pix[7:6];
            2'd1:    crumb = pix[5:4];
            2'd2:    crumb = pix[3:2];
            default: crumb = pix[1:0];
        endcase
        return crumb;
    endfunction

endpackage

// File: rtl/dpram.sv
// True dual-port RAM, read-old-data on both ports; only the read registers are reset.
module dpram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_din,
    input  logic          i_a_we,
    output logic [DW-1:0] o_a_q,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_din,
    input  logic          i_b_we,
    output logic [DW-1:0] o_b_q
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_a_q;
    logic [DW-1:0] r_b_q;

    always_ff @(posedge clk) begin
        if (i_a_we) r_mem[i_a_addr] <= i_a_din;
        if (i_b_we) r_mem[i_b_addr] <= i_b_din;
    end

    // Contents stay out of reset so the array maps onto block RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q <= '0;
            r_b_q <= '0;
        end else begin
            r_a_q <= r_mem[i_a_addr];
            r_b_q <= r_mem[i_b_addr];
        end
    end

    assign o_a_q = r_a_q;
    assign o_b_q = r_b_q;

endmodule

// File: rtl/video_fade.sv
// Frame-stepped brightness fader: moves bright one step per frame_stb toward a clamped target.
module video_fade
    import video_pkg::*;
#(
    parameter int FADE_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_frame_stb,
    input  logic [FADE_W:0] i_target,
    output logic [FADE_W:0] o_bright,
    output logic            o_busy
);

    localparam logic [FADE_W:0] FULL = {1'b1, {FADE_W{1'b0}}};

    fade_state_t     r_state;
    fade_state_t     w_state_next;
    logic [FADE_W:0] r_bright;
    logic [FADE_W:0] w_bright_next;
    logic            r_busy;
    logic            w_busy_next;
    logic [FADE_W:0] w_target;

    assign w_target = (i_target > FULL) ? FULL : i_target;

    // Direction is re-decided on every strobe, so a retarget mid-fade takes effect next frame.
    always_comb begin
        w_state_next  = r_state;
        w_bright_next = r_bright;
        w_busy_next   = r_busy;
        if (i_frame_stb) begin
            if (r_bright < w_target) begin
                w_state_next  = FADE_UP;
                w_bright_next = r_bright + 1'b1;
            end else if (r_bright > w_target) begin
                w_state_next  = FADE_DOWN;
                w_bright_next = r_bright - 1'b1;
            end else begin
                w_state_next  = FADE_IDLE;
            end
            w_busy_next = (w_bright_next != w_target);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FADE_IDLE;
            r_bright <= FULL;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bright <= w_bright_next;
            r_busy   <= w_busy_next;
        end
    end

    assign o_bright = r_bright;
    assign o_busy   = r_busy;

endmodule

// File: rtl/video_out_pal.sv
// Palette video output: pixel demux, palette lookup, brightness fade, channel expansion, blanking.
module video_out_pal
    import video_pkg::*;
#(
    parameter int COMP_W = 5,
    parameter int CH_W   = 8,
    parameter int PAL_AW = 8,
    parameter int FADE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_en,
    input  logic [7:0]            vplex_in,
    input  logic [1:0]            plex_sel,
    input  logic [1:0]            mode,
    input  logic [PAL_AW-1:0]     palsel,
    input  logic                  tv_blank,
    input  logic [PAL_AW-1:0]     cram_addr,
    input  logic [3*COMP_W:0]     cram_data,
    input  logic                  cram_we,
    output logic [3*COMP_W:0]     cram_q,
    input  logic [FADE_W:0]       fade_target,
    input  logic                  frame_stb,
    output logic                  fade_busy,
    output logic [CH_W-1:0]       vred,
    output logic [CH_W-1:0]       vgrn,
    output logic [CH_W-1:0]       vblu,
    output logic                  vdac_mode
);

    localparam int DW = 3*COMP_W + 1;
    localparam int PW = COMP_W + FADE_W + 1;

    logic [7:0]             r_vplex;
    logic [PAL_AW-1:0]      w_index;
    logic [DW-1:0]          w_pal_q;
    logic [FADE_W:0]        w_bright;
    logic                   r_blank_d1;
    logic                   r_dac;
    logic [2:0][CH_W-1:0]   w_exp;
    logic [2:0][CH_W-1:0]   r_chan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vplex <= '0;
        else if (pix_en) r_vplex <= vplex_in;
    end

    // Palette offset supplies the bits above the pixel field for the active depth.
    always_comb begin
        w_index = palsel;
        case (mode)
            MODE_4BPP: w_index[3:0] = plex_sel[1] ? r_vplex[3:0] : r_vplex[7:4];
            MODE_2BPP: w_index[1:0] = crumb_sel(r_vplex, plex_sel);
            default:   w_index[7:0] = r_vplex;
        endcase
    end

    dpram #(.AW(PAL_AW), .DW(DW)) u_cram (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_a_addr (cram_addr),
        .i_a_din  (cram_data),
        .i_a_we   (cram_we),
        .o_a_q    (cram_q),
        .i_b_addr (w_index),
        .i_b_din  ('0),
        .i_b_we   (1'b0),
        .o_b_q    (w_pal_q)
    );

    video_fade #(.FADE_W(FADE_W)) u_fade (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_frame_stb (frame_stb),
        .i_target    (fade_target),
        .o_bright    (w_bright),
        .o_busy      (fade_busy)
    );

    // Component gi: 0 = blue, 1 = green, 2 = red. Expansion repeats the scaled value MSB-first.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_comp
            logic [COMP_W-1:0] w_c;
            logic [PW-1:0]     w_prod;
            logic [COMP_W-1:0] w_s;
            assign w_c    = w_pal_q[gi*COMP_W +: COMP_W];
            assign w_prod = PW'(w_c) * PW'(w_bright);
            assign w_s    = COMP_W'(w_prod >> FADE_W);
            for (gj = 0; gj < CH_W; gj++) begin : g_bit
                assign w_exp[gi][CH_W-1-gj] = w_s[COMP_W-1-(gj % COMP_W)];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank_d1 <= 1'b1;
            r_dac      <= 1'b0;
            r_chan     <= '0;
        end else begin
            r_blank_d1 <= tv_blank;
            r_dac      <= w_pal_q[3*COMP_W];
            r_chan     <= r_blank_d1 ? '0 : w_exp;
        end
    end

    assign vred      = r_chan[2];
    assign vgrn      = r_chan[1];
    assign vblu      = r_chan[0];
    assign vdac_mode = r_dac;

endmodule

// File: tb/tb_video_out_pal.sv
// Directed bench for video_out_pal: vector table for pixel indexing plus sequences for blank, RAM collision, fade and reset.
module tb_video_out_pal;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [7:0]  vplex_in;
    logic [1:0]  plex_sel;
    logic [1:0]  mode;
    logic [7:0]  palsel;
    logic        tv_blank;
    logic [7:0]  cram_addr;
    logic [15:0] cram_data;
    logic        cram_we;
    logic [15:0] cram_q;
    logic [4:0]  fade_target;
    logic        frame_stb;
    logic        fade_busy;
    logic [7:0]  vred, vgrn, vblu;
    logic        vdac_mode;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] shadow [256];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] palsel;
        logic [7:0] vplex;
        logic [1:0] psel;
        logic [7:0] idx;
    } vec_t;
    vec_t vecs [11];

    video_out_pal dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vplex_in(vplex_in),
        .plex_sel(plex_sel), .mode(mode), .palsel(palsel), .tv_blank(tv_blank),
        .cram_addr(cram_addr), .cram_data(cram_data), .cram_we(cram_we), .cram_q(cram_q),
        .fade_target(fade_target), .frame_stb(frame_stb), .fade_busy(fade_busy),
        .vred(vred), .vgrn(vgrn), .vblu(vblu), .vdac_mode(vdac_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pal_fn(input logic [7:0] a);
        logic [4:0] lo;
        lo = a[4:0];
        return {a[0], a[7:3], lo, ~lo};
    endfunction

    // Scale a 5-bit component by bright/16 and widen to 8 bits.
    function automatic logic [7:0] xch(input logic [4:0] c, input int b);
        logic [4:0] s;
        s = 5'((int'(c) * b) / 16);
        return {s, s[4:2]};
    endfunction

    task automatic wr_pal(input logic [7:0] a, input logic [15:0] d);
        cram_addr = a; cram_data = d; cram_we = 1'b1;
        tick();
        cram_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic chk_pix(input string name, input logic [7:0] idx, input int b);
        logic [15:0] w;
        w = shadow[idx];
        chk({name, "_r"}, vred, xch(w[14:10], b));
        chk({name, "_g"}, vgrn, xch(w[9:5], b));
        chk({name, "_b"}, vblu, xch(w[4:0], b));
        chk({name, "_dac"}, vdac_mode, w[15]);
    endtask

    task automatic show_pix(input logic [1:0] m, input logic [7:0] ps, input logic [7:0] px, input logic [1:0] sel);
        mode = m; palsel = ps; vplex_in = px; plex_sel = sel; pix_en = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic strobe();
        frame_stb = 1'b1;
        tick();
        frame_stb = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 8'h00, 8'h12, 2'd0, 8'h12};
        vecs[1]  = '{2'd3, 8'h00, 8'h12, 2'd3, 8'h12};
        vecs[2]  = '{2'd1, 8'hA0, 8'h3C, 2'd2, 8'hAC};
        vecs[3]  = '{2'd1, 8'hA0, 8'h3C, 2'd0, 8'hA3};
        vecs[4]  = '{2'd1, 8'hA0, 8'h3C, 2'd3, 8'hAC};
        vecs[5]  = '{2'd2, 8'h40, 8'h9C, 2'd2, 8'h43};
        vecs[6]  = '{2'd2, 8'h40, 8'h9C, 2'd0, 8'h42};
        vecs[7]  = '{2'd2, 8'h40, 8'h9C, 2'd1, 8'h41};
        vecs[8]  = '{2'd2, 8'h40, 8'h9C, 2'd3, 8'h40};
        vecs[9]  = '{2'd0, 8'hFF, 8'h5A, 2'd1, 8'h5A};
        vecs[10] = '{2'd1, 8'h0F, 8'h5A, 2'd1, 8'h05};

        rst_n = 1'b0; pix_en = 1'b0; vplex_in = '0; plex_sel = '0; mode = '0; palsel = '0;
        tv_blank = 1'b0; cram_addr = '0; cram_data = '0; cram_we = 1'b0;
        fade_target = 5'd16; frame_stb = 1'b0;
        tick(); tick();
        chk("rst_vred", vred, 0);
        chk("rst_vgrn", vgrn, 0);
        chk("rst_vblu", vblu, 0);
        chk("rst_vdac", vdac_mode, 0);
        chk("rst_busy", fade_busy, 0);
        chk("rst_cram_q", cram_q, 0);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < 256; a++) wr_pal(8'(a), pal_fn(8'(a)));
        wr_pal(8'h12, 16'h7C00);
        cram_addr = 8'h12;
        tick();
        chk("cpu_readback", cram_q, 16'h7C00);

        for (int i = 0; i < 11; i++) begin
            show_pix(vecs[i].mode, vecs[i].palsel, vecs[i].vplex, vecs[i].psel);
            $display("vec %0d mode=%0d palsel=%h vplex=%h sel=%0d idx=%h rgb=%h/%h/%h dac=%0d",
                     i, vecs[i].mode, vecs[i].palsel, vecs[i].vplex, vecs[i].psel, vecs[i].idx,
                     vred, vgrn, vblu, vdac_mode);
            chk_pix($sformatf("vec%0d", i), vecs[i].idx, 16);
        end

        pix_en = 1'b0; vplex_in = 8'h00;
        tick(); tick(); tick();
        chk_pix("pix_hold", 8'h05, 16);

        show_pix(2'd0, 8'h00, 8'h12, 2'd0);
        chk("red_full_r", vred, 8'hFF);
        chk("red_full_g", vgrn, 8'h00);
        chk("red_full_b", vblu, 8'h00);
        chk("red_full_dac", vdac_mode, 0);

        show_pix(2'd0, 8'h00, 8'h13, 2'd0);
        tv_blank = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tv_blank = 1'b0;
            $display("blank cycle %0d rgb=%h/%h/%h dac=%0d", k, vred, vgrn, vblu, vdac_mode);
            if (k == 2) begin
                chk("blank_r", vred, 0);
                chk("blank_g", vgrn, 0);
                chk("blank_b", vblu, 0);
                chk("blank_dac", vdac_mode, 1);
            end else begin
                chk_pix($sformatf("noblank%0d", k), 8'h13, 16);
            end
        end

        wr_pal(8'h05, 16'h0000);
        show_pix(2'd0, 8'h00, 8'h05, 2'd0);
        cram_addr = 8'h05; cram_data = 16'h03E0; cram_we = 1'b1;
        tick();
        cram_we = 1'b0;
        chk("coll_cpu_old", cram_q, 16'h0000);
        tick();
        chk("coll_cpu_new", cram_q, 16'h03E0);
        chk("coll_vid_old", vgrn, 8'h00);
        tick();
        chk("coll_vid_new", vgrn, 8'hFF);
        $display("collision addr 05 cram_q=%h vgrn=%h", cram_q, vgrn);

        show_pix(2'd0, 8'h00, 8'h12, 2'd0);
        fade_target = 5'd8;
        for (int k = 1; k <= 9; k++) begin
            strobe();
            chk($sformatf("fade8_busy%0d", k), fade_busy, (k < 8) ? 1 : 0);
            tick();
            chk($sformatf("fade8_red%0d", k), vred, xch(5'd31, (k < 8) ? 16 - k : 8));
            $display("fade strobe %0d vred=%h busy=%0d", k, vred, fade_busy);
        end
        chk("fade8_red_7b", vred, 8'h7B);

        fade_target = 5'd31;
        for (int k = 1; k <= 9; k++) begin
            strobe();
            chk($sformatf("clamp_busy%0d", k), fade_busy, (k < 8) ? 1 : 0);
        end
        tick();
        chk("clamp_red", vred, 8'hFF);

        fade_target = 5'd0;
        for (int k = 1; k <= 11; k++) strobe();
        tick();
        chk("down5_red", vred, xch(5'd31, 5));
        chk("down5_busy", fade_busy, 1);
        fade_target = 5'd10;
        strobe();
        tick();
        chk("retarget_red", vred, xch(5'd31, 6));
        fade_target = 5'd0;
        strobe();
        tick();
        chk("back5_red", vred, xch(5'd31, 5));

        #2 rst_n = 1'b0;
        #1;
        chk("arst_vred", vred, 0);
        chk("arst_vdac", vdac_mode, 0);
        chk("arst_busy", fade_busy, 0);
        chk("arst_cram_q", cram_q, 0);
        tick(); tick();
        rst_n = 1'b1;
        show_pix(2'd0, 8'h00, 8'h12, 2'd0);
        chk("post_rst_red", vred, 8'hFF);
        chk("post_rst_busy", fade_busy, 0);
        tick(); tick();
        chk("post_rst_busy_hold", fade_busy, 0);
        strobe();
        chk("post_rst_stb_busy", fade_busy, 1);
        tick();
        chk("post_rst_stb_red", vred, xch(5'd31, 15));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
